sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Responder end of the 32-bit single-data-rate SDRAM interface that the team's controller drives.
- Emulates an 11-row-bit, 8-column-bit, 4-bank SDRAM on a word-addressed internal memory array.
- Decodes controller commands, tracks bank state and the mode register, and returns read data after the programmed CAS latency.
- Used as a Verilator/bench device model and as a BRAM-backed SDRAM stand-in on small boards. Flags protocol errors.

Parameters:
- MEM_AW, 21, memory depth in 32-bit words is 2^MEM_AW; linear address {ba,row,col} is truncated to its low MEM_AW bits.
- REFCNT_W, 16, width of the saturating refresh counter.

Ports:
- clk  in  1  SDRAM command clock; all inputs sampled on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sd_cs, sd_ras, sd_cas, sd_we  in  1 each  command lines; cmd = {cs,ras,cas,we}.
- sd_ba  in  2  bank address.
- sd_addr  in  11  multiplexed row/column address.
- sd_dqm  in  4  byte masks; bit3 covers dq[31:24]; 1 = masked.
- sd_dq_in  in  32  write data from the controller.
- sd_dq_out  out  32  read data.
- sd_dq_oe  out  1  responder drives the bus.
- mode_reg  out  11  last loaded mode register.
- init_done  out  1  set once PRECHARGE-all has been followed by LOAD_MODE.
- refresh_cnt  out  REFCNT_W  AUTO_REFRESH commands seen, saturating.
- prot_err  out  1  sticky error flag.
- err_code  out  3  code of the most recent error.

Behaviour:
- Reset (async): all outputs 0; all banks closed; read pipeline flushed; sd_dq_oe drops immediately. Memory contents are not cleared.
- Commands: INHIBIT 1xxx and NOP 0111 do nothing.
- ACTIVE 0011: opens row sd_addr in bank ba. If that bank is already open: ERR_BANK_OPEN (1).
- READ 0101 and WRITE 0100:
  - Bank must be open, else ERR_BANK_CLOSED (2).
  - Column = sd_addr[7:0]. sd_addr[10]=1 auto-precharges the bank after the access.
- PRECHARGE 0010: sd_addr[10]=1 closes all banks, else closes bank ba. Closing an already-closed bank is legal.
- AUTO_REFRESH 0001:
  - Any bank open: ERR_REFRESH (3) and the counter does not increment.
  - Otherwise refresh_cnt increments and saturates at all-ones.
- LOAD_MODE 0000:
  - Any bank open: ERR_MODE (4) and mode_reg is unchanged.
  - Otherwise mode_reg <= sd_addr.
  - CL = mode_reg[6:4]; only 2 or 3 is valid. Burst length mode_reg[2:0] must be 000. Any other CL or burst length: ERR_MODE.
- Init: init_done sets on the first legal LOAD_MODE that follows a PRECHARGE-all.
  - Before init_done, ACTIVE/READ/WRITE raise ERR_NOT_INIT (5) and have no other effect.
- Write: sd_dq_in is sampled on the same edge as WRITE. Bytes with dqm=1 are left unchanged.
- Read timing:
  - READ sampled at edge k. sd_dq_out is registered and valid, with sd_dq_oe=1, from edge k+CL-1 to edge k+CL, so the controller samples at edge k+CL.
  - Read dqm is ignored.
  - Back-to-back READs are allowed every cycle; the pipeline holds CL entries.
- Write-to-read ordering: a WRITE at edge k followed by a READ of the same word at edge k+1 returns the new data.
- Bus contention: a WRITE sampled while sd_dq_oe=1 raises ERR_BUS (6). The write is still performed.
- Multiple errors in one cycle: the highest code wins. prot_err clears only on reset.

Optional Feature:
- Macro SDRAM_RESP_TIMING_CHECK_EN.
- When defined, per-bank cycle counters check:
  - tRCD >= 1 cycle from ACTIVE to READ/WRITE;
  - tRP >= 1 cycle from PRECHARGE to ACTIVE;
  - tRC >= 4 cycles from ACTIVE to ACTIVE on the same bank.
- A violation raises ERR_TIMING (7) and the command still executes.
- When undefined, no counters are built and code 7 is never produced.

Decomposition:
- Package sdram_pkg holds:
  - CMD_* 4-bit encodings;
  - mode register field positions (CL[6:4], BL[2:0]);
  - ERR_* codes 1-7.
- Sub-module sdram_resp_rdpipe: CL-selectable (2/3) delay line carrying {valid, data}; it drives sd_dq_out and sd_dq_oe.
- The memory array is inferred inside sdram_responder.

Test Plan:
- Init: PRECHARGE with addr[10]=1, two AUTO_REFRESH, LOAD_MODE 11'h020 -> init_done=1, mode_reg=11'h020, refresh_cnt=2, prot_err=0.
- Write and read, CL=2:
  - Stimulus: ACTIVE ba=1 row=0x155; WRITE col=0x2A, dq=32'hDEADBEEF, dqm=0; READ col=0x2A.
  - Response: sd_dq_oe=1 and sd_dq_out=32'hDEADBEEF exactly at edge k+1..k+2 relative to the READ.
- Byte mask:
  - Stimulus: write 32'h11223344 with dqm=0, then write 32'hAABBCCDD with dqm=4'b1100, then read.
  - Response: returns 32'h1122CCDD.
- CL=3 back-to-back:
  - Stimulus: LOAD_MODE 11'h030; READs on three consecutive cycles to three addresses.
  - Response: three consecutive valid data beats starting 2 cycles after the first READ.
- Errors:
  - READ on a closed bank -> prot_err=1, err_code=2.
  - AUTO_REFRESH with a bank open -> err_code=3, refresh_cnt unchanged.
- Reset mid-read: assert reset_n=0 one cycle after READ -> sd_dq_oe=0 immediately, init_done=0; no data beat appears after release.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM responder: commands, mode fields, error codes.
package sdram_pkg;

    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_NOP       = 4'b0111;

    localparam int CL_MSB = 6;
    localparam int CL_LSB = 4;
    localparam int BL_MSB = 2;
    localparam int BL_LSB = 0;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_BANK_OPEN   = 3'd1;
    localparam logic [2:0] ERR_BANK_CLOSED = 3'd2;
    localparam logic [2:0] ERR_REFRESH     = 3'd3;
    localparam logic [2:0] ERR_MODE        = 3'd4;
    localparam logic [2:0] ERR_NOT_INIT    = 3'd5;
    localparam logic [2:0] ERR_BUS         = 3'd6;
    localparam logic [2:0] ERR_TIMING      = 3'd7;

    localparam int T_RCD = 1;
    localparam int T_RP  = 1;
    localparam int T_RC  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PALL,
        S_READY
    } init_e;

    function automatic logic mode_legal(input logic [10:0] m);
        logic [2:0] cl;
        cl = m[CL_MSB:CL_LSB];
        return (cl == 3'd2 || cl == 3'd3) && (m[BL_MSB:BL_LSB] == 3'b000);
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between the controller (master) and responder (slave).
interface sdram_responder_if;

    logic        sd_cs;
    logic        sd_ras;
    logic        sd_cas;
    logic        sd_we;
    logic [1:0]  sd_ba;
    logic [10:0] sd_addr;
    logic [3:0]  sd_dqm;
    logic [31:0] sd_dq_in;
    logic [31:0] sd_dq_out;
    logic        sd_dq_oe;

    modport master (
        output sd_cs, sd_ras, sd_cas, sd_we,
        output sd_ba, sd_addr, sd_dqm, sd_dq_in,
        input  sd_dq_out, sd_dq_oe
    );

    modport slave (
        input  sd_cs, sd_ras, sd_cas, sd_we,
        input  sd_ba, sd_addr, sd_dqm, sd_dq_in,
        output sd_dq_out, sd_dq_oe
    );

endinterface

// File: rtl/sdram_resp_rdpipe.sv
// Read-data delay line: selects a CAS latency of 2 or 3 and drives the DQ bus.
module sdram_resp_rdpipe (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cl3,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic [31:0] dq_out,
    output logic        dq_oe
);

    logic        s1_valid;
    logic [31:0] s1_data;
    logic        sel_valid;
    logic [31:0] sel_data;

    assign sel_valid = cl3 ? s1_valid : in_valid;
    assign sel_data  = cl3 ? s1_data : in_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            dq_oe    <= 1'b0;
            dq_out   <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_data  <= in_data;
            dq_oe    <= sel_valid;
            dq_out   <= sel_valid ? sel_data : '0;
        end
    end

endmodule

// File: rtl/sdram_responder.sv
// SDRAM responder: command decode, bank/mode tracking, error flags, memory.
// Define SDRAM_RESP_TIMING_CHECK_EN to build per-bank tRCD/tRP/tRC checks.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_AW   = 21,
    parameter int REFCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    sdram_responder_if.slave    bus,
    output logic [10:0]         mode_reg,
    output logic                init_done,
    output logic [REFCNT_W-1:0] refresh_cnt,
    output logic                prot_err,
    output logic [2:0]          err_code
);

    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [10:0] addr;

    assign cmd  = {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we};
    assign ba   = bus.sd_ba;
    assign addr = bus.sd_addr;

    logic is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;

    assign is_act = (cmd == CMD_ACTIVE);
    assign is_rd  = (cmd == CMD_READ);
    assign is_wr  = (cmd == CMD_WRITE);
    assign is_pre = (cmd == CMD_PRECHARGE);
    assign is_ref = (cmd == CMD_REFRESH);
    assign is_lmr = (cmd == CMD_LOAD_MODE);

    logic [3:0]  open_q;
    logic [10:0] row_q [4];
    logic        bank_open, any_open, lmr_ok;
    logic        do_act, do_rd, do_wr, auto_pre;

    assign bank_open = open_q[ba];
    assign any_open  = |open_q;
    assign lmr_ok    = is_lmr && !any_open && mode_legal(addr);
    assign do_act    = is_act && init_done && !bank_open;
    assign do_rd     = is_rd && init_done && bank_open;
    assign do_wr     = is_wr && init_done && bank_open;
    assign auto_pre  = (do_rd || do_wr) && addr[10];

    init_e st_q, st_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) st_q <= S_IDLE;
        else          st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            S_IDLE:  if (is_pre && addr[10]) st_d = S_PALL;
            S_PALL:  if (lmr_ok) st_d = S_READY;
            S_READY: st_d = S_READY;
            default: st_d = S_IDLE;
        endcase
    end

    assign init_done = (st_q == S_READY);

    logic e_open, e_closed, e_ref, e_mode, e_init, e_bus, e_tim;

    assign e_init   = (is_act || is_rd || is_wr) && !init_done;
    assign e_open   = is_act && init_done && bank_open;
    assign e_closed = (is_rd || is_wr) && init_done && !bank_open;
    assign e_ref    = is_ref && any_open;
    assign e_mode   = is_lmr && !lmr_ok;
    assign e_bus    = is_wr && init_done && bus.sd_dq_oe;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    logic [2:0] act_cnt [4];
    logic [2:0] pre_cnt [4];
    logic [3:0] pre_hit;

    always_comb begin
        pre_hit = '0;
        if (is_pre) pre_hit = addr[10] ? 4'hF : (4'b0001 << ba);
        if (auto_pre) pre_hit[ba] = 1'b1;
    end

    // Counters saturate so a long-idle bank never reports a violation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                act_cnt[i] <= '1;
                pre_cnt[i] <= '1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (do_act && ba == 2'(i))  act_cnt[i] <= '0;
                else if (act_cnt[i] != '1) act_cnt[i] <= act_cnt[i] + 1'b1;
                if (pre_hit[i])             pre_cnt[i] <= '0;
                else if (pre_cnt[i] != '1) pre_cnt[i] <= pre_cnt[i] + 1'b1;
            end
        end
    end

    assign e_tim = init_done && (
        ((is_rd || is_wr) && bank_open && (int'(act_cnt[ba]) + 1 < T_RCD)) ||
        (is_act && (int'(pre_cnt[ba]) + 1 < T_RP)) ||
        (is_act && (int'(act_cnt[ba]) + 1 < T_RC)));
`else
    assign e_tim = 1'b0;
`endif

    logic [2:0] err_now;

    // Later assignments win, so the highest code is reported.
    always_comb begin
        err_now = ERR_NONE;
        if (e_open)   err_now = ERR_BANK_OPEN;
        if (e_closed) err_now = ERR_BANK_CLOSED;
        if (e_ref)    err_now = ERR_REFRESH;
        if (e_mode)   err_now = ERR_MODE;
        if (e_init)   err_now = ERR_NOT_INIT;
        if (e_bus)    err_now = ERR_BUS;
        if (e_tim)    err_now = ERR_TIMING;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_q <= '0;
            row_q  <= '{default: '0};
        end else begin
            if (do_act) begin
                open_q[ba] <= 1'b1;
                row_q[ba]  <= addr;
            end
            if (auto_pre) open_q[ba] <= 1'b0;
            if (is_pre) begin
                if (addr[10]) open_q     <= '0;
                else          open_q[ba] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_reg    <= '0;
            refresh_cnt <= '0;
            prot_err    <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            if (lmr_ok) mode_reg <= addr;
            if (is_ref && !any_open && refresh_cnt != '1)
                refresh_cnt <= refresh_cnt + 1'b1;
            if (err_now != ERR_NONE) begin
                prot_err <= 1'b1;
                err_code <= err_now;
            end
        end
    end

    logic [31:0]       mem [2**MEM_AW];
    logic [20:0]       lin;
    logic [MEM_AW-1:0] idx;
    logic [31:0]       rd_data_q;
    logic              rd_valid_q;

    assign lin = {ba, row_q[ba], addr[7:0]};
    assign idx = MEM_AW'(lin);

    // Memory is never reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (!bus.sd_dqm[b]) mem[idx][8*b +: 8] <= bus.sd_dq_in[8*b +: 8];
            end
        end
        if (do_rd) rd_data_q <= mem[idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_valid_q <= 1'b0;
        else          rd_valid_q <= do_rd;
    end

    sdram_resp_rdpipe u_rdpipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .cl3      (mode_reg[CL_MSB:CL_LSB] == 3'd3),
        .in_valid (rd_valid_q),
        .in_data  (rd_data_q),
        .dq_out   (bus.sd_dq_out),
        .dq_oe    (bus.sd_dq_oe)
    );

endmodule

// File: tb/tb_sdram_responder.sv
// Randomised scoreboard bench for sdram_responder against a command-level model.
module tb_sdram_responder;

    localparam int AW = 12;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   mode_reg;
    logic          init_done;
    logic [RW-1:0] refresh_cnt;
    logic          prot_err;
    logic [2:0]    err_code;

    sdram_responder_if bus();

    sdram_responder #(.MEM_AW(AW), .REFCNT_W(RW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .mode_reg    (mode_reg),
        .init_done   (init_done),
        .refresh_cnt (refresh_cnt),
        .prot_err    (prot_err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];
    bit    beat_due[int];

    bit          m_init, m_pall, m_perr;
    bit [10:0]   m_mode;
    int          m_ref;
    bit [2:0]    m_ecode;
    bit [3:0]    m_open;
    bit [10:0]   m_row [4];
    logic [31:0] m_mem [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        while (exp_q.size() != 0 && exp_q[0].due < edge_n) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_beat: got none expected %h at edge %0d", e.data, e.due);
        end
        if (bus.sd_dq_oe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_beat: got %h expected no beat (edge %0d)", bus.sd_dq_out, edge_n);
            end else begin
                e = exp_q.pop_front();
                if (e.due != edge_n || bus.sd_dq_out !== e.data) begin
                    errors++;
                    $display("FAIL read_beat: got %h@%0d expected %h@%0d",
                             bus.sd_dq_out, edge_n, e.data, e.due);
                end
            end
        end
    end

    function automatic int mlin(input logic [1:0] ba, input logic [7:0] col);
        return ((int'(ba) << 19) + (int'(m_row[ba]) << 8) + int'(col)) % (1 << AW);
    endfunction

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_init = 0; m_pall = 0; m_perr = 0; m_mode = '0;
        m_ref = 0; m_ecode = '0; m_open = '0;
        exp_q.delete();
        beat_due.delete();
    endtask

    task automatic apply(input logic [3:0] c, input logic [1:0] ba, input logic [10:0] a,
                         input logic [3:0] dqm, input logic [31:0] d, input int k);
        int          e;
        int          lin;
        int          cl;
        logic [31:0] w;
        e = 0;
        lin = mlin(ba, a[7:0]);
        case (c)
            4'b0011: begin
                if (!m_init) e = 5;
                else if (m_open[ba]) e = 1;
                else begin m_open[ba] = 1; m_row[ba] = a; end
            end
            4'b0101, 4'b0100: begin
                if (!m_init) e = 5;
                else begin
                    if (c == 4'b0100 && beat_due.exists(k - 1)) e = 6;
                    if (!m_open[ba]) e = maxi(e, 2);
                    else begin
                        if (c == 4'b0100) begin
                            w = m_mem.exists(lin) ? m_mem[lin] : 32'h0;
                            for (int b = 0; b < 4; b++)
                                if (!dqm[b]) w[8*b +: 8] = d[8*b +: 8];
                            m_mem[lin] = w;
                        end else begin
                            cl = int'(m_mode[6:4]);
                            exp_q.push_back('{due: k + cl - 1, data: m_mem[lin]});
                            beat_due[k + cl - 1] = 1;
                        end
                        if (a[10]) m_open[ba] = 0;
                    end
                end
            end
            4'b0010: begin
                if (a[10]) begin m_open = '0; m_pall = 1; end
                else m_open[ba] = 0;
            end
            4'b0001: begin
                if (m_open != 0) e = 3;
                else if (m_ref < (1 << RW) - 1) m_ref++;
            end
            4'b0000: begin
                if (m_open != 0 || !(a[6:4] == 3'd2 || a[6:4] == 3'd3) || a[2:0] != 0) e = 4;
                else begin
                    m_mode = a;
                    if (m_pall) m_init = 1;
                end
            end
            default: ;
        endcase
        if (e != 0) begin m_perr = 1; m_ecode = 3'(e); end
    endtask

    task automatic check_status();
        chk("mode_reg", 32'(mode_reg), 32'(m_mode));
        chk("init_done", 32'(init_done), 32'(m_init));
        chk("refresh_cnt", 32'(refresh_cnt), 32'(m_ref));
        chk("prot_err", 32'(prot_err), 32'(m_perr));
        chk("err_code", 32'(err_code), 32'(m_ecode));
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [10:0] a,
                         input logic [3:0] dqm, input logic [31:0] d);
        {bus.sd_cs, bus.sd_ras, bus.sd_cas, bus.sd_we} = c;
        bus.sd_ba = ba;
        bus.sd_addr = a;
        bus.sd_dqm = dqm;
        bus.sd_dq_in = d;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [10:0] a,
                         input logic [3:0] dqm, input logic [31:0] d);
        drive(c, ba, a, dqm, d);
        @(posedge clk);
        #1;
        apply(c, ba, a, dqm, d, edge_n);
        drive(4'b0111, 2'd0, 11'd0, 4'd0, 32'd0);
        check_status();
    endtask

    task automatic nop();
        issue(4'b0111, 2'd0, 11'd0, 4'd0, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            nop();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [1:0]  ba;
        logic [10:0] a;
        logic [3:0]  dqm;
        logic [31:0] d;
        int          r;
        bit          wr;

        model_reset();
        drive(4'b0111, 2'd0, 11'd0, 4'd0, 32'd0);
        #2;
        check_status();
        chk("reset_oe", 32'(bus.sd_dq_oe), 32'd0);
        chk("reset_dq", bus.sd_dq_out, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        issue(4'b0010, 2'd0, 11'h400, 4'd0, 32'd0);
        issue(4'b0001, 2'd0, 11'h000, 4'd0, 32'd0);
        issue(4'b0001, 2'd0, 11'h000, 4'd0, 32'd0);
        issue(4'b0000, 2'd0, 11'h020, 4'd0, 32'd0);
        chk("init_done_set", 32'(init_done), 32'd1);
        chk("init_refcnt", 32'(refresh_cnt), 32'd2);

        issue(4'b0011, 2'd1, 11'h155, 4'd0, 32'd0);
        issue(4'b0100, 2'd1, 11'h02A, 4'd0, 32'hDEADBEEF);
        issue(4'b0101, 2'd1, 11'h02A, 4'd0, 32'd0);
        drain();

        issue(4'b0100, 2'd1, 11'h02B, 4'd0, 32'h11223344);
        issue(4'b0100, 2'd1, 11'h02B, 4'b1100, 32'hAABBCCDD);
        issue(4'b0101, 2'd1, 11'h02B, 4'd0, 32'd0);
        drain();

        issue(4'b0010, 2'd0, 11'h400, 4'd0, 32'd0);
        issue(4'b0000, 2'd0, 11'h030, 4'd0, 32'd0);
        issue(4'b0011, 2'd2, 11'h0AA, 4'd0, 32'd0);
        for (int i = 1; i <= 3; i++)
            issue(4'b0100, 2'd2, 11'(i), 4'd0, 32'hC0DE0000 + 32'(i));
        for (int i = 1; i <= 3; i++)
            issue(4'b0101, 2'd2, 11'(i), 4'hF, 32'd0);
        drain();
        issue(4'b0011, 2'd2, 11'h011, 4'd0, 32'd0);

        issue(4'b0010, 2'd0, 11'h400, 4'd0, 32'd0);
        issue(4'b0101, 2'd0, 11'h010, 4'd0, 32'd0);
        chk("closed_read_code", 32'(err_code), 32'd2);
        issue(4'b0011, 2'd0, 11'h007, 4'd0, 32'd0);
        issue(4'b0001, 2'd0, 11'h000, 4'd0, 32'd0);
        chk("refresh_err_code", 32'(err_code), 32'd3);
        issue(4'b0010, 2'd0, 11'h400, 4'd0, 32'd0);
        repeat (7) issue(4'b0001, 2'd0, 11'h000, 4'd0, 32'd0);
        chk("refresh_sat", 32'(refresh_cnt), 32'd7);

        issue(4'b0000, 2'd0, 11'h020, 4'd0, 32'd0);
        issue(4'b0011, 2'd0, 11'h003, 4'd0, 32'd0);
        issue(4'b0100, 2'd0, 11'h005, 4'd0, 32'h5A5A1234);
        nop();
        issue(4'b0101, 2'd0, 11'h005, 4'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("oe_pre_reset", 32'(bus.sd_dq_oe), 32'(beat_due.exists(edge_n)));
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("reset_oe_now", 32'(bus.sd_dq_oe), 32'd0);
        check_status();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) nop();

        issue(4'b0011, 2'd0, 11'h003, 4'd0, 32'd0);
        chk("not_init_code", 32'(err_code), 32'd5);
        issue(4'b0010, 2'd0, 11'h400, 4'd0, 32'd0);
        issue(4'b0000, 2'd0, 11'h020, 4'd0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            ba = 2'($urandom_range(0, 3));
            d = $urandom;
            if (r < 15) begin
                issue(4'b0011, ba, 11'($urandom_range(0, 31)), 4'd0, 32'd0);
            end else if (r < 70) begin
                a = {($urandom_range(0, 9) == 0), 2'b00, 8'($urandom_range(0, 15))};
                wr = (r < 45);
                dqm = 4'($urandom);
                if (m_open[ba] && !m_mem.exists(mlin(ba, a[7:0]))) begin
                    wr = 1;
                    dqm = 4'd0;
                end
                issue(wr ? 4'b0100 : 4'b0101, ba, a, dqm, d);
            end else if (r < 82) begin
                issue(4'b0010, ba, {($urandom_range(0, 2) == 0), 10'd0}, 4'd0, 32'd0);
            end else if (r < 88) begin
                issue(4'b0001, ba, 11'd0, 4'd0, 32'd0);
            end else if (r < 95) begin
                issue({1'b1, 3'($urandom)}, ba, 11'($urandom), 4'd0, d);
            end else begin
                drain();
                case ($urandom_range(0, 3))
                    0:       a = 11'h020;
                    1:       a = 11'h030;
                    2:       a = 11'h040;
                    default: a = 11'h031;
                endcase
                issue(4'b0000, 2'd0, a, 4'd0, 32'd0);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
